// File: rtl/spw_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : spw_tx_scheduler
// Purpose  : SpaceWire transmit-side token scheduler. Each token slot picks
//            the next token for the character encoder by priority
//            time-code > FCT > N-char (> NULL when NULL fill is built in).
//            Owns the TX credit counter (received FCT adds CREDIT_STEP,
//            transmitted N-char subtracts one) and acknowledges the RX-side
//            FCT request with a single-cycle pulse.
// Ports    : CLOCK, RESET          - clock, synchronous active-high reset
//            enableTx              - link transmit enable (low = idle+clear)
//            gotFct                - FCT received from far end (pulse)
//            sendFctReq/Ack        - FCT transmit request (level) / ack pulse
//            tickIn, timeIn        - time-code request and value
//            txFifoEmpty/Data/Read - show-ahead TX FIFO interface
//            encReady/Valid/Type/Data - encoder token handshake
//            creditTx, txCreditErr - TX credit and sticky overflow error
// Config   : `define SPW_TX_NULL_FILL_EN to emit NULL tokens when nothing
//            else is eligible; undefined, encValid stays low when idle.
// Revision : 1.0 - initial release
// ============================================================================
module spw_tx_scheduler #(
    parameter int CREDIT_MAX  = 56,
    parameter int CREDIT_STEP = 8
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       enableTx,
    input  logic       gotFct,
    input  logic       sendFctReq,
    output logic       sendFctAck,
    input  logic       tickIn,
    input  logic [7:0] timeIn,
    input  logic       txFifoEmpty,
    input  logic [8:0] txFifoData,
    output logic       txFifoRead,
    input  logic       encReady,
    output logic       encValid,
    output logic [1:0] encType,
    output logic [8:0] encData,
    output logic [5:0] creditTx,
    output logic       txCreditErr
);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SELECT = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam logic [1:0] c_TYPE_NULL  = 2'd0;
    localparam logic [1:0] c_TYPE_FCT   = 2'd1;
    localparam logic [1:0] c_TYPE_NCHAR = 2'd2;
    localparam logic [1:0] c_TYPE_TIME  = 2'd3;

    state_t      r_state;
    logic        r_enc_valid;
    logic [1:0]  r_enc_type;
    logic [8:0]  r_enc_data;
    logic [5:0]  r_credit;
    logic        r_credit_err;
    logic        r_tick_pend;
    logic [7:0]  r_tick_val;

    logic        w_active;
    logic        w_xfer;
    logic        w_xfer_fct;
    logic        w_xfer_nchar;
    logic        w_xfer_time;
    logic [6:0]  w_credit_add;
    logic [6:0]  w_credit_sum;
    logic        w_overflow;
    logic        w_sel_valid;
    logic [1:0]  w_sel_type;
    logic [8:0]  w_sel_data;

    // Side effects are combinational so they coincide with the accepting
    // cycle; this matters for the show-ahead FIFO, whose head must advance
    // before the next selection looks at it. Gating with reset/enable keeps
    // an aborted token from popping the FIFO or acking the FCT request.
    assign w_active     = enableTx & ~RESET;
    assign w_xfer       = w_active & r_enc_valid & encReady;
    assign w_xfer_fct   = w_xfer & (r_enc_type == c_TYPE_FCT);
    assign w_xfer_nchar = w_xfer & (r_enc_type == c_TYPE_NCHAR);
    assign w_xfer_time  = w_xfer & (r_enc_type == c_TYPE_TIME);

    // Credit update in 7 bits so an overflow past CREDIT_MAX is visible
    // before truncation. The N-char decrement never underflows because an
    // N-char is only selectable with non-zero credit.
    assign w_credit_add = gotFct ? 7'(CREDIT_STEP) : 7'd0;
    assign w_credit_sum = {1'b0, r_credit} + w_credit_add - {6'd0, w_xfer_nchar};
    assign w_overflow   = gotFct & (w_credit_sum > 7'(CREDIT_MAX));

    // Token priority selection, used only in ST_SELECT.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_type  = c_TYPE_NULL;
        w_sel_data  = 9'd0;
        if (r_tick_pend) begin
            w_sel_valid = 1'b1;
            w_sel_type  = c_TYPE_TIME;
            w_sel_data  = {1'b0, r_tick_val};
        end else if (sendFctReq) begin
            w_sel_valid = 1'b1;
            w_sel_type  = c_TYPE_FCT;
        end else if (!txFifoEmpty && (r_credit != 6'd0)) begin
            w_sel_valid = 1'b1;
            w_sel_type  = c_TYPE_NCHAR;
            w_sel_data  = txFifoData;
        end else begin
`ifdef SPW_TX_NULL_FILL_EN
            w_sel_valid = 1'b1;
`else
            w_sel_valid = 1'b0;
`endif
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET || !enableTx) begin
            r_state      <= ST_OFF;
            r_enc_valid  <= 1'b0;
            r_enc_type   <= c_TYPE_NULL;
            r_enc_data   <= 9'd0;
            r_credit     <= 6'd0;
            r_credit_err <= 1'b0;
            r_tick_pend  <= 1'b0;
            r_tick_val   <= 8'd0;
        end else begin
            // Overflowing FCT leaves the credit untouched and latches the error.
            if (w_overflow) begin
                r_credit_err <= 1'b1;
            end else begin
                r_credit <= w_credit_sum[5:0];
            end

            // A new tick wins over the clear so a tick arriving in the
            // transfer cycle of the previous code is not lost.
            if (tickIn) begin
                r_tick_pend <= 1'b1;
                r_tick_val  <= timeIn;
            end else if (w_xfer_time) begin
                r_tick_pend <= 1'b0;
            end

            case (r_state)
                ST_OFF: begin
                    r_state <= ST_SELECT;
                end
                ST_SELECT: begin
                    if (w_sel_valid) begin
                        r_enc_valid <= 1'b1;
                        r_enc_type  <= w_sel_type;
                        r_enc_data  <= w_sel_data;
                        r_state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_xfer) begin
                        r_enc_valid <= 1'b0;
                        r_enc_type  <= c_TYPE_NULL;
                        r_enc_data  <= 9'd0;
                        r_state     <= ST_SELECT;
                    end
                end
                default: begin
                    r_state <= ST_OFF;
                end
            endcase
        end
    end

    assign sendFctAck  = w_xfer_fct;
    assign txFifoRead  = w_xfer_nchar;
    assign encValid    = r_enc_valid;
    assign encType     = r_enc_type;
    assign encData     = r_enc_data;
    assign creditTx    = r_credit;
    assign txCreditErr = r_credit_err;

endmodule
`default_nettype wire

// File: tb/tb_spw_tx_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_spw_tx_scheduler
// Purpose  : Self-checking bench for spw_tx_scheduler (default build, no
//            NULL fill). Expected tokens are queued when stimulus is applied
//            and compared when the encoder handshake completes. A small
//            show-ahead FIFO model and an FCT requester model surround the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spw_tx_scheduler;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic       enableTx = 1'b0;
    logic       gotFct = 1'b0;
    logic       sendFctReq = 1'b0;
    logic       sendFctAck;
    logic       tickIn = 1'b0;
    logic [7:0] timeIn = 8'd0;
    logic       txFifoEmpty = 1'b1;
    logic [8:0] txFifoData = 9'd0;
    logic       txFifoRead;
    logic       encReady = 1'b0;
    logic       encValid;
    logic [1:0] encType;
    logic [8:0] encData;
    logic [5:0] creditTx;
    logic       txCreditErr;

    spw_tx_scheduler #(.CREDIT_MAX(56), .CREDIT_STEP(8)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .enableTx(enableTx), .gotFct(gotFct),
        .sendFctReq(sendFctReq), .sendFctAck(sendFctAck),
        .tickIn(tickIn), .timeIn(timeIn),
        .txFifoEmpty(txFifoEmpty), .txFifoData(txFifoData), .txFifoRead(txFifoRead),
        .encReady(encReady), .encValid(encValid), .encType(encType), .encData(encData),
        .creditTx(creditTx), .txCreditErr(txCreditErr)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct packed {
        logic [1:0] t;
        logic [8:0] d;
    } tok_t;

    int         total = 0;
    int         bad   = 0;
    tok_t       exp_q[$];
    logic [8:0] fifo_q[$];
    int         pop_cnt = 0;
    logic       pop_now = 1'b0;
    logic [8:0] pop_tmp;
    int         fct_issued = 0;
    int         fct_acked  = 0;
    tok_t       mon_e;

    // Show-ahead FIFO model: pops on the edge after a sampled txFifoRead.
    always begin
        @(posedge CLOCK);
        if (pop_now && fifo_q.size() > 0) begin
            pop_tmp = fifo_q.pop_front();
            pop_cnt++;
        end
        #1;
        txFifoEmpty = (fifo_q.size() == 0);
        txFifoData  = (fifo_q.size() == 0) ? 9'd0 : fifo_q[0];
        @(negedge CLOCK);
        pop_now     = txFifoRead;
        txFifoEmpty = (fifo_q.size() == 0);
        txFifoData  = (fifo_q.size() == 0) ? 9'd0 : fifo_q[0];
    end

    // RX-side FCT requester: holds the request until each one is acked.
    always begin
        @(negedge CLOCK);
        if (sendFctAck) fct_acked++;
        sendFctReq = (fct_issued != fct_acked);
    end

    // Scoreboard monitor: compares every accepted token and its side effect.
    always @(negedge CLOCK) begin
        if (!RESET && enableTx && encValid && encReady) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL token_unexpected got type=%0d data=%h, none expected", encType, encData);
            end else begin
                mon_e = exp_q.pop_front();
                if ({encType, encData} !== {mon_e.t, mon_e.d}) begin
                    bad++;
                    $display("FAIL token got type=%0d data=%h exp type=%0d data=%h",
                             encType, encData, mon_e.t, mon_e.d);
                end
                total++;
                if (txFifoRead !== (mon_e.t == 2'd2)) begin
                    bad++;
                    $display("FAIL token_pop got=%b exp=%b", txFifoRead, (mon_e.t == 2'd2));
                end
                total++;
                if (sendFctAck !== (mon_e.t == 2'd1)) begin
                    bad++;
                    $display("FAIL token_ack got=%b exp=%b", sendFctAck, (mon_e.t == 2'd1));
                end
            end
        end else begin
            total++;
            if (txFifoRead !== 1'b0 || sendFctAck !== 1'b0) begin
                bad++;
                $display("FAIL spurious_side_effect pop=%b ack=%b exp 0/0", txFifoRead, sendFctAck);
            end
        end
    end

    task automatic cyc();
        @(posedge CLOCK);
        #2;
    endtask

    task automatic test_reset();
        logic seen;
        RESET = 1'b1; enableTx = 1'b1; tickIn = 1'b1; timeIn = 8'h55; gotFct = 1'b1;
        repeat (3) cyc();
        total++; if (encValid !== 1'b0) begin bad++; $display("FAIL rst_encValid got=%b exp=0", encValid); end
        total++; if (encType !== 2'd0) begin bad++; $display("FAIL rst_encType got=%0d exp=0", encType); end
        total++; if (encData !== 9'd0) begin bad++; $display("FAIL rst_encData got=%h exp=0", encData); end
        total++; if (creditTx !== 6'd0) begin bad++; $display("FAIL rst_credit got=%0d exp=0", creditTx); end
        total++; if (txCreditErr !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", txCreditErr); end
        total++; if (sendFctAck !== 1'b0 || txFifoRead !== 1'b0) begin
            bad++; $display("FAIL rst_pulses got ack=%b pop=%b exp 0/0", sendFctAck, txFifoRead);
        end
        tickIn = 1'b0; gotFct = 1'b0; RESET = 1'b0;
        seen = 1'b0;
        repeat (6) begin cyc(); if (encValid === 1'b1) seen = 1'b1; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_idle_valid got=1 exp=0"); end
        total++; if (creditTx !== 6'd0) begin bad++; $display("FAIL rst_idle_credit got=%0d exp=0", creditTx); end
    endtask

    task automatic test_nchar_basic();
        int p0;
        encReady = 1'b1;
        p0 = pop_cnt;
        fifo_q.push_back(9'h041); fifo_q.push_back(9'h042); fifo_q.push_back(9'h100);
        exp_q.push_back('{2'd2, 9'h041}); exp_q.push_back('{2'd2, 9'h042}); exp_q.push_back('{2'd2, 9'h100});
        cyc();
        gotFct = 1'b1;
        cyc();
        gotFct = 1'b0;
        total++; if (creditTx !== 6'd8) begin bad++; $display("FAIL basic_credit8 got=%0d exp=8", creditTx); end
        total++; if (encValid !== 1'b0) begin bad++; $display("FAIL basic_zero_credit_valid got=%b exp=0", encValid); end
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) cyc();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL basic_drain left=%0d exp=0", exp_q.size()); end
        total++; if (creditTx !== 6'd5) begin bad++; $display("FAIL basic_credit5 got=%0d exp=5", creditTx); end
        total++; if (pop_cnt - p0 != 3) begin bad++; $display("FAIL basic_pops got=%0d exp=3", pop_cnt - p0); end
    endtask

    task automatic test_zero_credit();
        for (int i = 0; i < 5; i++) begin
            fifo_q.push_back(9'(9'h010 + i));
            exp_q.push_back('{2'd2, 9'(9'h010 + i)});
        end
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) cyc();
        cyc();
        total++; if (creditTx !== 6'd0) begin bad++; $display("FAIL zc_credit0 got=%0d exp=0", creditTx); end
        fifo_q.push_back(9'h101); fifo_q.push_back(9'h07E);
        repeat (8) cyc();
        total++; if (encValid !== 1'b0) begin bad++; $display("FAIL zc_blocked_valid got=%b exp=0", encValid); end
        total++; if (fifo_q.size() != 2) begin bad++; $display("FAIL zc_blocked_fifo got=%0d exp=2", fifo_q.size()); end
        exp_q.push_back('{2'd2, 9'h101}); exp_q.push_back('{2'd2, 9'h07E});
        gotFct = 1'b1;
        cyc();
        gotFct = 1'b0;
        total++; if (creditTx !== 6'd8) begin bad++; $display("FAIL zc_credit8 got=%0d exp=8", creditTx); end
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) cyc();
        cyc();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL zc_drain left=%0d exp=0", exp_q.size()); end
        total++; if (creditTx !== 6'd6) begin bad++; $display("FAIL zc_credit6 got=%0d exp=6", creditTx); end
    endtask

    task automatic test_priority();
        int a0;
        a0 = fct_acked;
        encReady = 1'b1;
        tickIn = 1'b1; timeIn = 8'h2A;
        cyc();
        tickIn = 1'b0; timeIn = 8'h00;
        fct_issued++;
        fifo_q.push_back(9'h0AB);
        exp_q.push_back('{2'd3, 9'h02A});
        exp_q.push_back('{2'd1, 9'h000});
        exp_q.push_back('{2'd2, 9'h0AB});
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) cyc();
        cyc();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL prio_drain left=%0d exp=0", exp_q.size()); end
        total++; if (fct_acked - a0 != 1) begin bad++; $display("FAIL prio_acks got=%0d exp=1", fct_acked - a0); end
        total++; if (creditTx !== 6'd5) begin bad++; $display("FAIL prio_credit got=%0d exp=5", creditTx); end
    endtask

    task automatic test_credit_overflow();
        encReady = 1'b0;
        enableTx = 1'b0; cyc(); enableTx = 1'b1;
        gotFct = 1'b1; repeat (7) cyc(); gotFct = 1'b0;
        total++; if (creditTx !== 6'd56) begin bad++; $display("FAIL ovf_credit56 got=%0d exp=56", creditTx); end
        total++; if (txCreditErr !== 1'b0) begin bad++; $display("FAIL ovf_noerr got=%b exp=0", txCreditErr); end
        gotFct = 1'b1; cyc(); gotFct = 1'b0;
        total++; if (creditTx !== 6'd56) begin bad++; $display("FAIL ovf_credit_hold got=%0d exp=56", creditTx); end
        total++; if (txCreditErr !== 1'b1) begin bad++; $display("FAIL ovf_err got=%b exp=1", txCreditErr); end
        repeat (3) cyc();
        total++; if (txCreditErr !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", txCreditErr); end
        enableTx = 1'b0; cyc();
        total++; if (txCreditErr !== 1'b0 || creditTx !== 6'd0) begin
            bad++; $display("FAIL ovf_disable_clear got err=%b credit=%0d exp 0/0", txCreditErr, creditTx);
        end
        enableTx = 1'b1;
        gotFct = 1'b1; repeat (7) cyc(); gotFct = 1'b0;
        for (int i = 0; i < 8; i++) begin
            fifo_q.push_back(9'(9'h080 + i));
            exp_q.push_back('{2'd2, 9'(9'h080 + i)});
        end
        for (int k = 0; k < 8; k++) begin
            for (int w = 0; w < 10 && encValid !== 1'b1; w++) cyc();
            total++; if (encValid !== 1'b1) begin bad++; $display("FAIL ovf_wait_valid k=%0d got=0 exp=1", k); end
            encReady = 1'b1;
            if (k == 7) gotFct = 1'b1;
            cyc();
            encReady = 1'b0; gotFct = 1'b0;
            if (k == 6) begin
                total++; if (creditTx !== 6'd49) begin bad++; $display("FAIL ovf_credit49 got=%0d exp=49", creditTx); end
            end
        end
        total++; if (creditTx !== 6'd56) begin bad++; $display("FAIL ovf_plus7 got=%0d exp=56", creditTx); end
        total++; if (txCreditErr !== 1'b0) begin bad++; $display("FAIL ovf_plus7_err got=%b exp=0", txCreditErr); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL ovf_drain left=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_stall_disable();
        int p0;
        encReady = 1'b0;
        fifo_q.push_back(9'h0C3);
        exp_q.push_back('{2'd2, 9'h0C3});
        for (int w = 0; w < 10 && encValid !== 1'b1; w++) cyc();
        total++; if (encValid !== 1'b1) begin bad++; $display("FAIL stall_wait_valid got=0 exp=1"); end
        p0 = pop_cnt;
        for (int k = 0; k < 5; k++) begin
            total++; if (encType !== 2'd2 || encData !== 9'h0C3) begin
                bad++; $display("FAIL stall_hold k=%0d got type=%0d data=%h exp 2/0c3", k, encType, encData);
            end
            cyc();
        end
        total++; if (pop_cnt != p0) begin bad++; $display("FAIL stall_no_pop got=%0d exp=0", pop_cnt - p0); end
        enableTx = 1'b0;
        cyc();
        total++; if (encValid !== 1'b0) begin bad++; $display("FAIL dis_valid got=%b exp=0", encValid); end
        total++; if (creditTx !== 6'd0) begin bad++; $display("FAIL dis_credit got=%0d exp=0", creditTx); end
        total++; if (pop_cnt != p0 || fifo_q.size() != 1) begin
            bad++; $display("FAIL dis_no_pop got pops=%0d fifo=%0d exp 0/1", pop_cnt - p0, fifo_q.size());
        end
        exp_q.delete();
        fifo_q.delete();
        cyc();
    endtask

    task automatic test_reset_mid_fct();
        int a0;
        enableTx = 1'b1; RESET = 1'b0; encReady = 1'b0;
        a0 = fct_acked;
        fct_issued++;
        exp_q.push_back('{2'd1, 9'h000});
        for (int w = 0; w < 10 && encValid !== 1'b1; w++) cyc();
        total++; if (encValid !== 1'b1 || encType !== 2'd1) begin
            bad++; $display("FAIL rmid_fct_valid got valid=%b type=%0d exp 1/1", encValid, encType);
        end
        RESET = 1'b1; encReady = 1'b1;
        #1;
        total++; if (sendFctAck !== 1'b0) begin bad++; $display("FAIL rmid_ack_now got=%b exp=0", sendFctAck); end
        cyc();
        total++; if (encValid !== 1'b0 || encType !== 2'd0 || encData !== 9'd0) begin
            bad++; $display("FAIL rmid_outputs got v=%b t=%0d d=%h exp 0/0/0", encValid, encType, encData);
        end
        total++; if (creditTx !== 6'd0 || txCreditErr !== 1'b0) begin
            bad++; $display("FAIL rmid_credit got=%0d err=%b exp 0/0", creditTx, txCreditErr);
        end
        fct_issued = fct_acked;
        exp_q.delete();
        repeat (2) cyc();
        RESET = 1'b0; encReady = 1'b0;
        repeat (3) cyc();
        total++; if (fct_acked != a0) begin bad++; $display("FAIL rmid_no_ack got=%0d exp=0", fct_acked - a0); end
        total++; if (encValid !== 1'b0) begin bad++; $display("FAIL rmid_idle got=%b exp=0", encValid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nchar_basic();
        test_zero_credit();
        test_priority();
        test_credit_overflow();
        test_stall_disable();
        test_reset_mid_fct();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spw_tx_scheduler.md
Name: spw_tx_scheduler

Overview:
- Transmit-side scheduler for the SpaceWire link.
- Each cycle, picks the next token to hand to the character encoder, by priority: time-code > FCT > N-char > NULL.
- Owns the TX credit counter: received FCTs add 8, transmitted N-chars subtract 1.
- Consumes the FCT request from the RX credit controller and returns a single-cycle acknowledge.

Parameters:
- CREDIT_MAX, 56, credit ceiling; a received FCT that would exceed it raises txCreditErr.
- CREDIT_STEP, 8, credit added per received FCT.

Ports:
- CLOCK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- enableTx  in  1  link-FSM transmit enable; low forces idle and clears state.
- gotFct  in  1  one-cycle pulse per FCT received from the far end.
- sendFctReq  in  1  level request to transmit one FCT, held until acked.
- sendFctAck  out  1  one-cycle pulse in the cycle the FCT is accepted by the encoder.
- tickIn  in  1  one-cycle time-code request.
- timeIn  in  8  time-code value, sampled with tickIn.
- txFifoEmpty  in  1  show-ahead TX FIFO empty flag.
- txFifoData  in  9  FIFO head; bit8=1 marks EOP/EEP control char.
- txFifoRead  out  1  one-cycle pop, in the cycle the N-char is accepted.
- encReady  in  1  encoder can accept a token this cycle.
- encValid  out  1  token valid; held stable until encReady.
- encType  out  2  0=NULL, 1=FCT, 2=N-char, 3=time-code.
- encData  out  9  N-char data or {1'b0,time}; 0 for NULL/FCT.
- creditTx  out  6  current TX credit, 0..56.
- txCreditErr  out  1  sticky credit-overflow error.

Behaviour:
- Reset (RESET=1 at clock edge) values: encValid=0, encType=0, encData=0, sendFctAck=0, txFifoRead=0, creditTx=0, txCreditErr=0, tick pending=0, FSM=ST_OFF.
- enableTx=0 has the same effect as reset on every register, including mid-transfer: encValid drops next cycle and no side effects fire.
- FSM ST_OFF: when enableTx=1, go to ST_SELECT.
- FSM ST_SELECT: evaluate priority, load the output register, assert encValid, go to ST_HOLD.
  - If nothing is eligible and there is no NULL fill, stay in ST_SELECT with encValid=0.
- FSM ST_HOLD: encType/encData frozen while encValid=1 and encReady=0. On encValid&encReady (transfer):
  - fire the side effect for the token type;
  - go to ST_SELECT, so the next token is valid 1 cycle after transfer (min 2 cycles per token).
- Eligibility, checked in ST_SELECT only:
  - time-code: tick pending=1;
  - FCT: sendFctReq=1;
  - N-char: txFifoEmpty=0 AND creditTx!=0.
- Side effects, all in the transfer cycle:
  - FCT: sendFctAck=1 for exactly 1 cycle.
  - N-char: txFifoRead=1 for 1 cycle; creditTx decrements.
  - Time-code: tick pending clears.
- Tick pending: set by tickIn, with timeIn latched. A tickIn while pending overwrites the latched value, still one code sent. A tickIn in the same cycle as a time-code transfer sets pending again with the new value.
- Credit arithmetic, with 7-bit internal sum:
  - gotFct alone: +8.
  - gotFct and N-char transfer in the same cycle: +7.
  - If the resulting sum exceeds CREDIT_MAX: creditTx unchanged, txCreditErr=1.
  - txCreditErr stays set until RESET or enableTx=0.
  - creditTx never wraps below 0, because N-char is ineligible at 0.
- sendFctReq dropping while an FCT is in ST_HOLD: the token is still sent and acked.

Optional Feature:
- Macro: SPW_TX_NULL_FILL_EN.
- Defined: when nothing is eligible, ST_SELECT issues NULL (encType=0), so encValid is continuously 1 while enabled.
- Undefined: encValid=0 when idle and NULLs are generated elsewhere; all other behaviour is identical.

Test Plan:
- Reset, then enableTx=1, gotFct x1, FIFO holding 3 chars, encReady=1 -> 3 N-char transfers, creditTx 8->5, 3 txFifoRead pulses.
- creditTx=0, FIFO non-empty -> no N-char issued (NULL if fill enabled). Then gotFct -> creditTx=8 and N-char issued on the next select.
- tickIn (timeIn=0x2A), sendFctReq and FIFO data all pending, encReady=1 -> order: time-code 0x2A, then FCT with 1-cycle sendFctAck, then N-char.
- creditTx=56 and gotFct -> txCreditErr=1, creditTx stays 56. creditTx=49, gotFct and N-char transfer in the same cycle -> creditTx=56, no error.
- encReady=0 for 5 cycles with an N-char valid -> encData stable, no txFifoRead. enableTx=0 mid-hold -> encValid=0 next cycle, creditTx=0, no pop, no ack.
- RESET asserted mid-transfer while sendFctReq=1 -> all outputs at reset values next cycle, sendFctAck never pulses.
